// File: rtl/tt_vec_mul_seq_if.sv
// Request/response bundle between an issuing unit and tt_vec_mul_seq.
// The master issues ops and takes results; the slave is the sequencer.
interface tt_vec_mul_seq_if #(
   parameter int VLEN = 256,
   parameter int VLW  = $clog2(VLEN/8)+1
);
   logic            req_vld;
   logic            req_rdy;
   logic [1:0]      op;
   logic [1:0]      sew;
   logic [VLW-1:0]  vl;
   logic [VLEN-1:0] src1;
   logic [VLEN-1:0] src2;
   logic [VLEN-1:0] vd_old;
   logic            resp_vld;
   logic            resp_rdy;
   logic [VLEN-1:0] resp_data;

   modport master (
      output req_vld, op, sew, vl, src1, src2, vd_old, resp_rdy,
      input  req_rdy, resp_vld, resp_data
   );

   modport slave (
      input  req_vld, op, sew, vl, src1, src2, vd_old, resp_rdy,
      output req_rdy, resp_vld, resp_data
   );
endinterface

// File: rtl/tt_vec_mul_seq.sv
// Sequences one vector multiply op through the single-cycle tt_vec_mul_dp lane bank.
// Latency: result valid at A+2+passes (A+1 when vl=0); one op in flight at a time.
// Backpressure: result held in RESP until resp_rdy; TT_VEC_MUL_SEQ_PERF_EN adds busy/stall counters.
module tt_vec_mul_seq #(
   parameter int VLEN = 256,
   parameter int VLW  = $clog2(VLEN/8)+1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   tt_vec_mul_seq_if.slave          req_if,
   output logic [VLEN/8-1:0][63:0]  o_sized_src1_0a,
   output logic [VLEN/8-1:0][63:0]  o_sized_src2_0a,
   output logic                     o_issgn_0a,
   output logic                     o_issgnsrc2_0a,
   output logic                     o_mulen_0a,
   input  logic [VLEN/8-1:0][128:0] i_sum_1a
`ifdef TT_VEC_MUL_SEQ_PERF_EN
   ,
   output logic [31:0]              o_perf_busy_cnt,
   output logic [31:0]              o_perf_stall_cnt
`endif
);

   localparam int PE8  = VLEN/16;
   localparam int PE16 = VLEN/32;
   localparam int PE32 = VLEN/64;
   localparam int PE64 = VLEN/64;

   typedef enum logic [2:0] {IDLE, PASS0, PASS1, CAP, RESP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, sew_q, np_q;
   logic [VLW-1:0]  vl_q;
   logic [VLEN-1:0] src1_q, src2_q, res_q, res_d;
   logic            cap_q, cap_pass_q;
   logic            mulen, accept, hi;
   logic [VLW-1:0]  vl_max, pe_in, vl_clamp;
   logic [1:0]      np_in;
   int              ps, cs;

   // Clamp vl to the element count of the selected SEW and derive the pass count.
   always_comb begin
      vl_max = VLW'(VLEN/8);
      pe_in  = VLW'(PE8);
      case (req_if.sew)
         2'd0: begin vl_max = VLW'(VLEN/8);  pe_in = VLW'(PE8);  end
         2'd1: begin vl_max = VLW'(VLEN/16); pe_in = VLW'(PE16); end
         2'd2: begin vl_max = VLW'(VLEN/32); pe_in = VLW'(PE32); end
         default: begin vl_max = VLW'(VLEN/64); pe_in = VLW'(PE64); end
      endcase
      vl_clamp = (req_if.vl > vl_max) ? vl_max : req_if.vl;
      if (vl_clamp == '0)
         np_in = 2'd0;
      else if (req_if.sew == 2'd3 || vl_clamp <= pe_in)
         np_in = 2'd1;
      else
         np_in = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      mulen   = 1'b0;
      case (state_q)
         IDLE:  if (req_if.req_vld) state_d = (np_in == 2'd0) ? RESP : PASS0;
         PASS0: begin
            mulen   = 1'b1;
            state_d = (np_q == 2'd2) ? PASS1 : CAP;
         end
         PASS1: begin
            mulen   = 1'b1;
            state_d = CAP;
         end
         CAP:   state_d = RESP;
         RESP:  if (req_if.resp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign accept         = req_if.req_vld && (state_q == IDLE);
   assign hi             = (op_q != 2'd0);
   assign ps             = (state_q == PASS1) ? 1 : 0;
   assign cs             = cap_pass_q ? 1 : 0;
   assign req_if.req_rdy = (state_q == IDLE);
   assign req_if.resp_vld  = (state_q == RESP);
   assign req_if.resp_data = res_q;
   assign o_mulen_0a     = mulen;
   assign o_issgn_0a     = mulen && (op_q != 2'd2);
   assign o_issgnsrc2_0a = mulen && (op_q[1] == 1'b0);

   // Lane steering for the pass being issued and capture of the pass issued last cycle.
   // Tail elements keep vd_old because captures beyond vl are simply skipped.
   always_comb begin
      o_sized_src1_0a = '0;
      o_sized_src2_0a = '0;
      res_d = accept ? req_if.vd_old : res_q;
      case (sew_q)
         2'd0: for (int k = 0; k < PE8; k++) begin
            if (mulen) begin
               o_sized_src1_0a[PE8+k] = 64'(src1_q[(ps*PE8+k)*8 +: 8]);
               o_sized_src2_0a[PE8+k] = 64'(src2_q[(ps*PE8+k)*8 +: 8]);
            end
            if (cap_q && (cs*PE8+k) < int'(vl_q))
               res_d[(cs*PE8+k)*8 +: 8] = hi ? i_sum_1a[PE8+k][15:8] : i_sum_1a[PE8+k][7:0];
         end
         2'd1: for (int k = 0; k < PE16; k++) begin
            if (mulen) begin
               o_sized_src1_0a[PE16+k] = 64'(src1_q[(ps*PE16+k)*16 +: 16]);
               o_sized_src2_0a[PE16+k] = 64'(src2_q[(ps*PE16+k)*16 +: 16]);
            end
            if (cap_q && (cs*PE16+k) < int'(vl_q))
               res_d[(cs*PE16+k)*16 +: 16] = hi ? i_sum_1a[PE16+k][31:16] : i_sum_1a[PE16+k][15:0];
         end
         2'd2: for (int k = 0; k < PE32; k++) begin
            if (mulen) begin
               o_sized_src1_0a[PE32+k] = 64'(src1_q[(ps*PE32+k)*32 +: 32]);
               o_sized_src2_0a[PE32+k] = 64'(src2_q[(ps*PE32+k)*32 +: 32]);
            end
            if (cap_q && (cs*PE32+k) < int'(vl_q))
               res_d[(cs*PE32+k)*32 +: 32] = hi ? i_sum_1a[PE32+k][63:32] : i_sum_1a[PE32+k][31:0];
         end
         default: for (int k = 0; k < PE64; k++) begin
            if (mulen) begin
               o_sized_src1_0a[k] = src1_q[(ps*PE64+k)*64 +: 64];
               o_sized_src2_0a[k] = src2_q[(ps*PE64+k)*64 +: 64];
            end
            if (cap_q && (cs*PE64+k) < int'(vl_q))
               res_d[(cs*PE64+k)*64 +: 64] = hi ? i_sum_1a[k][127:64] : i_sum_1a[k][63:0];
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         op_q       <= '0;
         sew_q      <= '0;
         np_q       <= '0;
         vl_q       <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         res_q      <= '0;
         cap_q      <= 1'b0;
         cap_pass_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         cap_q      <= mulen;
         cap_pass_q <= (state_q == PASS1);
         if (accept) begin
            op_q   <= req_if.op;
            sew_q  <= req_if.sew;
            np_q   <= np_in;
            vl_q   <= vl_clamp;
            src1_q <= req_if.src1;
            src2_q <= req_if.src2;
         end
      end
   end

`ifdef TT_VEC_MUL_SEQ_PERF_EN
   logic [31:0] busy_q, stall_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         if (state_q != IDLE && busy_q != 32'hFFFF_FFFF)
            busy_q <= busy_q + 32'd1;
         if (state_q == RESP && !req_if.resp_rdy && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign o_perf_busy_cnt  = busy_q;
   assign o_perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_tt_vec_mul_seq.sv
// Bench for tt_vec_mul_seq: behavioural datapath model, directed and random ops, result scoreboard.
module tb_tt_vec_mul_seq;
   localparam int VLEN = 256;
   localparam int VLW  = $clog2(VLEN/8)+1;
   localparam int NL   = VLEN/8;

   logic i_clk = 1'b0;
   logic i_reset;
   always #5 i_clk = ~i_clk;

   tt_vec_mul_seq_if #(.VLEN(VLEN), .VLW(VLW)) bus();

   logic [NL-1:0][63:0]  s1l, s2l;
   logic [NL-1:0][128:0] sum;
   logic                 issgn, issgn2, mulen;
`ifdef TT_VEC_MUL_SEQ_PERF_EN
   logic [31:0]          busy_cnt, stall_cnt;
`endif

   tt_vec_mul_seq #(.VLEN(VLEN), .VLW(VLW)) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .req_if          (bus),
      .o_sized_src1_0a (s1l),
      .o_sized_src2_0a (s2l),
      .o_issgn_0a      (issgn),
      .o_issgnsrc2_0a  (issgn2),
      .o_mulen_0a      (mulen),
      .i_sum_1a        (sum)
`ifdef TT_VEC_MUL_SEQ_PERF_EN
      ,
      .o_perf_busy_cnt (busy_cnt),
      .o_perf_stall_cnt(stall_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cur_sewb = 8;
   int stall_acc = 0;
   logic [VLEN-1:0] sb_q[$];

   task automatic chk(string tag, logic [VLEN-1:0] got, logic [VLEN-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [128:0] dp_mul(logic [63:0] a, logic [63:0] b, int sb, logic sa, logic sbs);
      logic [128:0] m, xa, xb;
      m  = (129'd1 << sb) - 129'd1;
      xa = {65'd0, a} & m;
      xb = {65'd0, b} & m;
      if (sa && xa[sb-1]) xa = xa | ~m;
      if (sbs && xb[sb-1]) xb = xb | ~m;
      return xa * xb;
   endfunction

   function automatic logic [VLEN-1:0] exp_calc(int op, int sew, int vl, logic [VLEN-1:0] a,
                                                logic [VLEN-1:0] b, logic [VLEN-1:0] old);
      int sb = 8 << sew;
      int ne = VLEN / sb;
      int vle = (vl > ne) ? ne : vl;
      logic [VLEN-1:0] mv = VLEN'((129'd1 << sb) - 129'd1);
      logic [VLEN-1:0] r = '0;
      logic [128:0] p;
      logic [VLEN-1:0] f;
      for (int i = 0; i < ne; i++) begin
         p = dp_mul(64'((a >> (i*sb)) & mv), 64'((b >> (i*sb)) & mv), sb, op != 2, op <= 1);
         f = (op == 0) ? VLEN'(p) : VLEN'(p >> sb);
         if (i < vle) r = r | ((f & mv) << (i*sb));
         else         r = r | (((old >> (i*sb)) & mv) << (i*sb));
      end
      return r;
   endfunction

   always @(posedge i_clk) begin
      for (int l = 0; l < NL; l++)
         sum[l] <= (i_reset || !mulen) ? '0 : dp_mul(s1l[l], s2l[l], cur_sewb, issgn, issgn2);
   end

   task automatic run_op(string tag, int op, int sew, int vl, logic [VLEN-1:0] a, logic [VLEN-1:0] b,
                         logic [VLEN-1:0] old, logic [VLEN-1:0] exp, int hold);
      int sb, ne, vle, pe, base, np, lat, nmul, n;
      logic [VLEN-1:0] mv, held, got;
      logic [NL-1:0] mism;
      logic [63:0] e1, e2;
      sb = 8 << sew; ne = VLEN / sb; vle = (vl > ne) ? ne : vl;
      pe = (sew == 0) ? VLEN/16 : (sew == 1) ? VLEN/32 : VLEN/64;
      base = (sew == 3) ? 0 : pe;
      np = (vle == 0) ? 0 : ((sew == 3 || vle <= pe) ? 1 : 2);
      mv = VLEN'((129'd1 << sb) - 129'd1);
      n = 0;
      while (bus.req_rdy !== 1'b1 && n < 20) begin @(posedge i_clk); #1; n++; end
      chk({tag, "_req_rdy"}, VLEN'(bus.req_rdy), VLEN'(1));
      cur_sewb = sb;
      bus.op = 2'(op); bus.sew = 2'(sew); bus.vl = VLW'(vl);
      bus.src1 = a; bus.src2 = b; bus.vd_old = old; bus.req_vld = 1'b1;
      sb_q.push_back(exp);
      @(posedge i_clk); #1;
      bus.req_vld = 1'b0;
      lat = 0; nmul = 0;
      for (int c = 1; c <= 12; c++) begin
         if (mulen === 1'b1) begin
            mism = '0;
            for (int l = 0; l < NL; l++) begin
               e1 = '0; e2 = '0;
               if (l >= base && l < base + pe) begin
                  e1 = 64'((a >> ((nmul*pe + l - base)*sb)) & mv);
                  e2 = 64'((b >> ((nmul*pe + l - base)*sb)) & mv);
               end
               if (s1l[l] !== e1 || s2l[l] !== e2) mism[l] = 1'b1;
            end
            chk({tag, "_lanes"}, VLEN'(mism), '0);
            chk({tag, "_sgn"}, VLEN'({issgn, issgn2}), VLEN'({op != 2, op <= 1}));
            nmul++;
         end
         if (bus.resp_vld === 1'b1) begin lat = c; break; end
         @(posedge i_clk); #1;
      end
      chk({tag, "_lat"}, VLEN'(lat), VLEN'((np == 0) ? 1 : 2 + np));
      chk({tag, "_mulen_cnt"}, VLEN'(nmul), VLEN'(np));
      held = bus.resp_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge i_clk); #1;
         chk({tag, "_hold_data"}, bus.resp_data, held);
         chk({tag, "_hold_rdy"}, VLEN'({bus.req_rdy, bus.resp_vld}), VLEN'(2'b01));
      end
      stall_acc += hold;
      got = bus.resp_data;
      chk({tag, "_data"}, got, sb_q.pop_front());
      bus.resp_rdy = 1'b1;
      @(posedge i_clk); #1;
      bus.resp_rdy = 1'b0;
      chk({tag, "_after"}, VLEN'({bus.req_rdy, bus.resp_vld}), VLEN'(2'b10));
`ifdef TT_VEC_MUL_SEQ_PERF_EN
      chk({tag, "_stall_cnt"}, VLEN'(stall_cnt), VLEN'(stall_acc));
`endif
   endtask

   initial begin
      logic [VLEN-1:0] ra, rb, ro;
      int rop, rsew, rvl;
      i_reset = 1'b1;
      bus.req_vld = 1'b0; bus.op = '0; bus.sew = '0; bus.vl = '0;
      bus.src1 = '0; bus.src2 = '0; bus.vd_old = '0; bus.resp_rdy = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_ctl", VLEN'({bus.req_rdy, bus.resp_vld, mulen, issgn, issgn2}), VLEN'(5'b10000));
      chk("rst_data", bus.resp_data, '0);
      chk("rst_lanes", VLEN'({|s1l, |s2l}), '0);
`ifdef TT_VEC_MUL_SEQ_PERF_EN
      chk("rst_perf", VLEN'({busy_cnt, stall_cnt}), '0);
`endif
      i_reset = 1'b0;
      @(posedge i_clk); #1;

      run_op("vmul8",   0, 0, 32, {32{8'h7F}}, {32{8'h03}}, '0, {32{8'h7D}}, 0);
      run_op("vmulh8",  1, 0, 32, {32{8'h80}}, {32{8'h80}}, '0, {32{8'h40}}, 1);
      run_op("vmulhu8", 2, 0, 32, {32{8'hFF}}, {32{8'hFF}}, '0, {32{8'hFE}}, 0);
      run_op("vmulhsu8",3, 0, 32, {32{8'hFF}}, {32{8'hFF}}, '0, {32{8'hFF}}, 0);
      run_op("vmulhu64",2, 3, 4, '1, '1, '0, {4{64'hFFFF_FFFF_FFFF_FFFE}}, 0);
      run_op("tail16",  0, 0, 16, {32{8'h7F}}, {32{8'h03}}, {32{8'hAA}},
             {{16{8'hAA}}, {16{8'h7D}}}, 0);
      run_op("vl0",     0, 0, 0, {32{8'h7F}}, {32{8'h03}}, {32{8'hAA}}, {32{8'hAA}}, 5);
      run_op("clamp16", 1, 1, 40, {16{16'h8000}}, {16{16'h0002}}, '0, {16{16'hFFFF}}, 0);

      // Reset while the second pass is being issued.
      cur_sewb = 8;
      bus.op = 2'd0; bus.sew = 2'd0; bus.vl = VLW'(32);
      bus.src1 = {32{8'h11}}; bus.src2 = {32{8'h22}}; bus.vd_old = '0; bus.req_vld = 1'b1;
      @(posedge i_clk); #1;
      bus.req_vld = 1'b0;
      @(posedge i_clk); #1;
      chk("mid_pass1_mulen", VLEN'(mulen), VLEN'(1));
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      stall_acc = 0;
      chk("mid_rst_ctl", VLEN'({bus.req_rdy, bus.resp_vld, mulen}), VLEN'(3'b100));
      for (int c = 0; c < 4; c++) begin
         @(posedge i_clk); #1;
         chk("mid_rst_novld", VLEN'(bus.resp_vld), '0);
      end
      run_op("post_rst", 2, 2, 8, {8{32'h0001_0000}}, {8{32'h0003_0000}}, '0, {8{32'h0000_0003}}, 0);

      for (int t = 0; t < 10; t++) begin
         rop = $urandom_range(0, 3); rsew = $urandom_range(0, 3); rvl = $urandom_range(0, 40);
         for (int w = 0; w < VLEN/32; w++) begin
            ra[w*32 +: 32] = $urandom; rb[w*32 +: 32] = $urandom; ro[w*32 +: 32] = $urandom;
         end
         run_op($sformatf("rnd%0d", t), rop, rsew, rvl, ra, rb, ro,
                exp_calc(rop, rsew, rvl, ra, rb, ro), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
